// File: rtl/bcd_pkg.sv
// Shared widths, FSM state encoding and work-register layout for the serial BCD-to-binary converter.
package bcd_pkg;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned BCD_W      = 12;
  localparam int unsigned BIN_W      = 10;
  localparam int unsigned ITERS      = 10;
  localparam int unsigned WORK_W     = BCD_W + BIN_W;
  localparam int unsigned CNT_W      = $clog2(ITERS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Work register: BCD digits on top, binary result accumulates from the top of the low field.
  typedef struct packed {
    logic [BCD_W-1:0] bcd;
    logic [BIN_W-1:0] bin;
  } work_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction applied after each right shift: digits of 8 or more drop by 3.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q_c
);

  always_comb begin
    q_c = d;
    if (d >= DIGIT_W'(8)) begin
      q_c = d - DIGIT_W'(3);
    end
  end

endmodule : bcd_digit_adjust

// File: rtl/bcd_to_bin_serial.sv
// Serial three-digit BCD to 10-bit binary converter using a shift-right / subtract-3 loop.
module bcd_to_bin_serial
  import bcd_pkg::*;
(
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [BCD_W-1:0] bcd_in,
  output logic [BIN_W-1:0] bin_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  work_t            work_q, work_d;
  logic [BIN_W-1:0] bin_out_q, bin_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WORK_W-1:0] shifted_c;
  logic [BCD_W-1:0]  adj_bcd_c;
  work_t             work_step_c;
  logic              digit_bad_c;

  assign shifted_c = work_q >> 1;

  // One adjuster per digit of the freshly shifted BCD field.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d   (shifted_c[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .q_c (adj_bcd_c[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    work_step_c     = work_t'(shifted_c);
    work_step_c.bcd = adj_bcd_c;
  end

  always_comb begin
    digit_bad_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_in[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) begin
        digit_bad_c = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d.bcd = bcd_in;
          work_d.bin = BIN_W'(0);
          cnt_d      = CNT_W'(0);
          err_d      = 1'b0;
          if (digit_bad_c) begin
            err_d     = 1'b1;
            bin_out_d = BIN_W'(0);
            state_d   = DONE;
            done_d    = 1'b1;
          end else begin
            state_d = SHIFT;
            busy_d  = 1'b1;
          end
        end
      end

      SHIFT: begin
        work_d = work_step_c;
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          cnt_d     = CNT_W'(0);
          bin_out_d = work_step_c.bin;
          state_d   = DONE;
          done_d    = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_W'(0);
      work_q    <= work_t'(WORK_W'(0));
      bin_out_q <= BIN_W'(0);
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      bin_out_q <= bin_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bin_out = bin_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule : bcd_to_bin_serial

// File: tb/tb_bcd_to_bin_serial.sv
// Directed-vector bench for bcd_to_bin_serial with hand-computed results and cycle latencies.
module tb_bcd_to_bin_serial;

  logic        Clock;
  logic        Resetn;
  logic        start;
  logic [11:0] bcd_in;
  logic [9:0]  bin_out;
  logic        busy;
  logic        done;
  logic        err;

  int n_vec;
  int n_err;

  bcd_to_bin_serial dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present a request for one accepting edge; optionally keep start asserted afterwards.
  task automatic accept(input logic [11:0] b, input bit keep_start);
    bcd_in = b;
    start  = 1'b1;
    tick();
    if (!keep_start) begin
      start  = 1'b0;
      bcd_in = 12'hFFF;
    end
  endtask

  // Called in cycle 1 after the accepting edge; waits (bounded) for done and checks the result.
  task automatic finish(input string tag, input int exp_bin, input int exp_err, input int exp_lat);
    int lat;
    int nbusy;
    int hold_ok;
    logic [9:0] prev_bin;
    lat      = 0;
    nbusy    = 0;
    hold_ok  = 1;
    prev_bin = bin_out;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (busy) nbusy++;
      if (done) begin
        lat = c;
      end else begin
        if (bin_out !== prev_bin) hold_ok = 0;
        tick();
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_bin"}, int'(bin_out), exp_bin);
    chk({tag, "_err"}, int'(err), exp_err);
    chk({tag, "_busycnt"}, nbusy, exp_lat - 1);
    chk({tag, "_hold"}, hold_ok, 1);
    tick();
    chk({tag, "_donefall"}, int'(done), 0);
    chk({tag, "_idlebusy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ndone;
    n_vec  = 0;
    n_err  = 0;
    Resetn = 1'b0;
    start  = 1'b0;
    bcd_in = 12'h000;

    #12;
    chk("rst_bin", int'(bin_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    tick();
    Resetn = 1'b1;
    tick();

    accept(12'h999, 1'b0);
    finish("v999", 999, 0, 11);
    accept(12'h000, 1'b0);
    finish("v000", 0, 0, 11);
    accept(12'h509, 1'b0);
    finish("v509", 509, 0, 11);
    accept(12'h010, 1'b0);
    finish("v010", 10, 0, 11);
    accept(12'h1A5, 1'b0);
    finish("v1A5", 0, 1, 1);
    accept(12'h250, 1'b0);
    finish("v250", 250, 0, 11);
    accept(12'h90B, 1'b0);
    finish("v90B", 0, 1, 1);
    accept(12'h808, 1'b0);
    finish("v808", 808, 0, 11);

    // start held high; bcd_in changes right after acceptance
    accept(12'h123, 1'b1);
    bcd_in = 12'h456;
    finish("held1", 123, 0, 11);
    tick();
    chk("held2_accept_busy", int'(busy), 1);
    start = 1'b0;
    finish("held2", 456, 0, 11);

    // reset during iteration 5 of 0x777
    accept(12'h777, 1'b0);
    repeat (5) tick();
    chk("rst_mid_prebusy", int'(busy), 1);
    Resetn = 1'b0;
    #1;
    chk("rst_mid_bin", int'(bin_out), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_err", int'(err), 0);
    ndone = 0;
    repeat (2) begin
      tick();
      if (done) ndone++;
    end
    Resetn = 1'b1;
    repeat (12) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("rst_mid_nodone", ndone, 0);
    accept(12'h042, 1'b0);
    finish("v042", 42, 0, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_bcd_to_bin_serial
